// File: rtl/ooo_pkg.sv
// Shared widths and payload types for the result-writeback path
// (functional units to the CDB and the ROB write port).
package ooo_pkg;

    localparam int unsigned ROBID_W = 4;
    localparam int unsigned DATA_W  = 8;

    typedef struct packed {
        logic [ROBID_W-1:0] id;
        logic [DATA_W-1:0]  val;
    } cdb_msg_t;

    typedef struct packed {
        logic [ROBID_W-1:0] robid;
        logic [DATA_W-1:0]  flags;
        logic [DATA_W-1:0]  wbs;
        logic [DATA_W-1:0]  value;
    } rob_msg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the grant is combinational from req/ptr, and the
// pointer advances past the winner on every issued grant.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W-1:0] r_ptr;
    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_hi;
    logic [N-1:0]     w_pick;
    logic             w_any;

    // Requests at or above the pointer win first; otherwise wrap to the lowest index.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_mask[i] = (PTR_W'(i) >= r_ptr);
        end
    end

    assign w_hi   = req & w_mask;
    assign w_pick = (|w_hi) ? w_hi : req;
    assign w_any  = (|req) && en && !rst;

    always_comb begin
        grant_idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            grant[i] = w_any && (grant_idx == PTR_W'(i));
        end
    end

    // Explicit wrap compare keeps non-power-of-two N legal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fu_result_arbiter.sv
// Arbitrates all functional-unit results onto the single CDB and the single
// ROB write port; each channel has its own round-robin arbiter and output register.
module fu_result_arbiter
    import ooo_pkg::*;
#(
    parameter  int unsigned NUM_FU = 4,
    localparam int unsigned PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_FU-1:0]         cdb_req,
    input  logic [NUM_FU*ROBID_W-1:0] cdb_id_in,
    input  logic [NUM_FU*DATA_W-1:0]  cdb_val_in,
    output logic [NUM_FU-1:0]         cdb_grant,
    output logic                      cdb_valid,
    output logic [ROBID_W-1:0]        cdb_id,
    output logic [DATA_W-1:0]         cdb_val,
    input  logic [NUM_FU-1:0]         rob_req,
    input  logic [NUM_FU*ROBID_W-1:0] robid_in,
    input  logic [NUM_FU*DATA_W-1:0]  flags_in,
    input  logic [NUM_FU*DATA_W-1:0]  wbs_in,
    input  logic [NUM_FU*DATA_W-1:0]  value_in,
    input  logic                      rob_ready,
    output logic [NUM_FU-1:0]         rob_grant,
    output logic                      rob_valid,
    output logic [ROBID_W-1:0]        rob_id,
    output logic [DATA_W-1:0]         rob_flags,
    output logic [DATA_W-1:0]         rob_wbs,
    output logic [DATA_W-1:0]         rob_value
);

    logic [NUM_FU-1:0] w_cdb_grant;
    logic [PTR_W-1:0]  w_cdb_idx;
    cdb_msg_t          w_cdb_msg;
    logic              r_cdb_valid;
    cdb_msg_t          r_cdb_msg;

    logic [NUM_FU-1:0] w_rob_grant;
    logic [PTR_W-1:0]  w_rob_idx;
    rob_msg_t          w_rob_msg;
    logic              r_rob_valid;
    rob_msg_t          r_rob_msg;

    rr_arbiter #(.N(NUM_FU)) u_cdb_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (cdb_req),
        .en        (1'b1),
        .grant     (w_cdb_grant),
        .grant_idx (w_cdb_idx)
    );

    rr_arbiter #(.N(NUM_FU)) u_rob_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (rob_req),
        .en        (rob_ready),
        .grant     (w_rob_grant),
        .grant_idx (w_rob_idx)
    );

    // Winner payload select for both channels.
    always_comb begin
        w_cdb_msg = '0;
        w_rob_msg = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (w_cdb_idx == PTR_W'(i)) begin
                w_cdb_msg.id  = cdb_id_in[i*ROBID_W +: ROBID_W];
                w_cdb_msg.val = cdb_val_in[i*DATA_W +: DATA_W];
            end
            if (w_rob_idx == PTR_W'(i)) begin
                w_rob_msg.robid = robid_in[i*ROBID_W +: ROBID_W];
                w_rob_msg.flags = flags_in[i*DATA_W +: DATA_W];
                w_rob_msg.wbs   = wbs_in[i*DATA_W +: DATA_W];
                w_rob_msg.value = value_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Payload holds when idle; only the valid bit drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_valid <= 1'b0;
            r_cdb_msg   <= '0;
            r_rob_valid <= 1'b0;
            r_rob_msg   <= '0;
        end else begin
            r_cdb_valid <= |w_cdb_grant;
            r_rob_valid <= |w_rob_grant;
            if (|w_cdb_grant) begin
                r_cdb_msg <= w_cdb_msg;
            end
            if (|w_rob_grant) begin
                r_rob_msg <= w_rob_msg;
            end
        end
    end

    assign cdb_grant = w_cdb_grant;
    assign cdb_valid = r_cdb_valid;
    assign cdb_id    = r_cdb_msg.id;
    assign cdb_val   = r_cdb_msg.val;

    assign rob_grant = w_rob_grant;
    assign rob_valid = r_rob_valid;
    assign rob_id    = r_rob_msg.robid;
    assign rob_flags = r_rob_msg.flags;
    assign rob_wbs   = r_rob_msg.wbs;
    assign rob_value = r_rob_msg.value;

endmodule

// File: tb/tb_fu_result_arbiter.sv
// Bench for fu_result_arbiter: modulo-scan reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fu_result_arbiter;

    localparam int N  = 4;
    localparam int RW = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    cdb_req;
    logic [N*RW-1:0] cdb_id_in;
    logic [N*DW-1:0] cdb_val_in;
    logic [N-1:0]    cdb_grant;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_id;
    logic [DW-1:0]   cdb_val;
    logic [N-1:0]    rob_req;
    logic [N*RW-1:0] robid_in;
    logic [N*DW-1:0] flags_in;
    logic [N*DW-1:0] wbs_in;
    logic [N*DW-1:0] value_in;
    logic            rob_ready;
    logic [N-1:0]    rob_grant;
    logic            rob_valid;
    logic [RW-1:0]   rob_id;
    logic [DW-1:0]   rob_flags;
    logic [DW-1:0]   rob_wbs;
    logic [DW-1:0]   rob_value;

    fu_result_arbiter #(.NUM_FU(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .cdb_req    (cdb_req),
        .cdb_id_in  (cdb_id_in),
        .cdb_val_in (cdb_val_in),
        .cdb_grant  (cdb_grant),
        .cdb_valid  (cdb_valid),
        .cdb_id     (cdb_id),
        .cdb_val    (cdb_val),
        .rob_req    (rob_req),
        .robid_in   (robid_in),
        .flags_in   (flags_in),
        .wbs_in     (wbs_in),
        .value_in   (value_in),
        .rob_ready  (rob_ready),
        .rob_grant  (rob_grant),
        .rob_valid  (rob_valid),
        .rob_id     (rob_id),
        .rob_flags  (rob_flags),
        .rob_wbs    (rob_wbs),
        .rob_value  (rob_value)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int            m_ptr_c = 0;
    int            m_ptr_r = 0;
    logic          e_cv    = 1'b0;
    logic [RW-1:0] e_cid   = '0;
    logic [DW-1:0] e_cval  = '0;
    logic          e_rv    = 1'b0;
    logic [RW-1:0] e_rid   = '0;
    logic [DW-1:0] e_rfl   = '0;
    logic [DW-1:0] e_rwbs  = '0;
    logic [DW-1:0] e_rval  = '0;
    int            cdb_log[$];

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : model_chk
        int         wc;
        int         wr;
        logic [N-1:0] gc;
        logic [N-1:0] gr;
        wc = rst ? -1 : rr_pick(cdb_req, m_ptr_c);
        wr = (rst || !rob_ready) ? -1 : rr_pick(rob_req, m_ptr_r);
        gc = '0;
        gr = '0;
        if (wc >= 0) gc[wc] = 1'b1;
        if (wr >= 0) gr[wr] = 1'b1;

        check("m_cdb_grant", 32'(cdb_grant), 32'(gc));
        check("m_rob_grant", 32'(rob_grant), 32'(gr));
        check("m_cdb_valid", 32'(cdb_valid), 32'(e_cv));
        check("m_cdb_id",    32'(cdb_id),    32'(e_cid));
        check("m_cdb_val",   32'(cdb_val),   32'(e_cval));
        check("m_rob_valid", 32'(rob_valid), 32'(e_rv));
        check("m_rob_id",    32'(rob_id),    32'(e_rid));
        check("m_rob_flags", 32'(rob_flags), 32'(e_rfl));
        check("m_rob_wbs",   32'(rob_wbs),   32'(e_rwbs));
        check("m_rob_value", 32'(rob_value), 32'(e_rval));

        // Advance the model to what the coming edge must produce
        if (rst) begin
            m_ptr_c = 0;  m_ptr_r = 0;
            e_cv = 1'b0;  e_cid = '0; e_cval = '0;
            e_rv = 1'b0;  e_rid = '0; e_rfl = '0; e_rwbs = '0; e_rval = '0;
        end else begin
            e_cv = (wc >= 0);
            e_rv = (wr >= 0);
            if (wc >= 0) begin
                e_cid   = cdb_id_in[wc*RW +: RW];
                e_cval  = cdb_val_in[wc*DW +: DW];
                m_ptr_c = (wc + 1) % N;
                cdb_log.push_back(wc);
            end
            if (wr >= 0) begin
                e_rid   = robid_in[wr*RW +: RW];
                e_rfl   = flags_in[wr*DW +: DW];
                e_rwbs  = wbs_in[wr*DW +: DW];
                e_rval  = value_in[wr*DW +: DW];
                m_ptr_r = (wr + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cdb(input int i, input logic [RW-1:0] id, input logic [DW-1:0] v);
        cdb_id_in[i*RW +: RW]  = id;
        cdb_val_in[i*DW +: DW] = v;
    endtask

    task automatic set_rob(input int i, input logic [RW-1:0] id, input logic [DW-1:0] fl,
                           input logic [DW-1:0] wb, input logic [DW-1:0] v);
        robid_in[i*RW +: RW] = id;
        flags_in[i*DW +: DW] = fl;
        wbs_in[i*DW +: DW]   = wb;
        value_in[i*DW +: DW] = v;
    endtask

    initial begin
        int exp_order[8];
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        rst       = 1'b1;
        cdb_req   = '1;
        rob_req   = '1;
        rob_ready = 1'b1;
        cdb_id_in = '0; cdb_val_in = '0;
        robid_in  = '0; flags_in = '0; wbs_in = '0; value_in = '0;
        for (int i = 0; i < N; i++) begin
            set_cdb(i, RW'(i + 5), DW'(16 * (i + 1)));
            set_rob(i, RW'(i + 1), DW'(i), DW'(i + 2), DW'(32 + i));
        end

        // Reset with every request high
        step(); #1;
        check("rst_cdb_grant", 32'(cdb_grant), 32'h0);
        check("rst_rob_grant", 32'(rob_grant), 32'h0);

        step(); rst = 1'b0; #1;
        check("post_rst_cdb_valid", 32'(cdb_valid), 32'h0);
        check("post_rst_cdb_id",    32'(cdb_id),    32'h0);
        check("post_rst_rob_valid", 32'(rob_valid), 32'h0);
        check("post_rst_rob_value", 32'(rob_value), 32'h0);
        check("first_cdb_grant",    32'(cdb_grant), 32'h1);
        check("first_rob_grant",    32'(rob_grant), 32'h1);

        // CDB round-robin with all four requesting
        for (int c = 1; c < 8; c++) begin
            step();
            rob_req = '0;
            for (int i = 0; i < N; i++) cdb_val_in[i*DW +: DW] = DW'(c * 16 + i);
            #1;
            check("rr_cdb_valid", 32'(cdb_valid), 32'h1);
        end
        step(); cdb_req = '0; #1;
        check("rr_last_cdb_id",  32'(cdb_id),    32'h8);
        check("rr_last_cdb_val", 32'(cdb_val),   32'h73);
        check("rr_idle_grant",   32'(cdb_grant), 32'h0);
        check("rr_log_len",      32'(cdb_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < cdb_log.size()) check("rr_order", 32'(cdb_log[k]), 32'(exp_order[k]));
        end

        // Pointer skip: after FU1, pattern 0011 goes to FU0, then FU1
        step(); cdb_req = 4'b0001; #1;
        check("skip_pre0", 32'(cdb_grant), 32'h1);
        step(); cdb_req = 4'b0010; #1;
        check("skip_pre1", 32'(cdb_grant), 32'h2);
        step(); cdb_req = 4'b0011; #1;
        check("skip_fu0", 32'(cdb_grant), 32'h1);
        step(); cdb_req = 4'b0011; #1;
        check("skip_ptr1", 32'(cdb_grant), 32'h2);

        // ROB backpressure
        for (int c = 0; c < 3; c++) begin
            step();
            cdb_req   = '0;
            rob_req   = 4'b0100;
            rob_ready = 1'b0;
            set_rob(2, 4'hA, 8'h5A, 8'h77, 8'h3C);
            #1;
            check("bp_rob_grant", 32'(rob_grant), 32'h0);
            check("bp_rob_valid", 32'(rob_valid), 32'h0);
        end
        step(); rob_ready = 1'b1; #1;
        check("bp_release_grant", 32'(rob_grant), 32'h4);
        step(); rob_req = '0; #1;
        check("bp_rob_valid_hi", 32'(rob_valid), 32'h1);
        check("bp_rob_id",       32'(rob_id),    32'hA);
        check("bp_rob_value",    32'(rob_value), 32'h3C);
        check("bp_rob_flags",    32'(rob_flags), 32'h5A);
        check("bp_rob_wbs",      32'(rob_wbs),   32'h77);
        step(); #1;
        check("bp_rob_pulse", 32'(rob_valid), 32'h0);

        // FU3 wins both channels in one cycle
        step();
        cdb_req = 4'b1000;
        rob_req = 4'b1000;
        set_cdb(3, 4'h9, 8'hD4);
        set_rob(3, 4'hC, 8'h11, 8'h22, 8'hE1);
        #1;
        check("dual_cdb_grant", 32'(cdb_grant), 32'h8);
        check("dual_rob_grant", 32'(rob_grant), 32'h8);
        step(); cdb_req = '0; rob_req = '0; #1;
        check("dual_cdb_valid", 32'(cdb_valid), 32'h1);
        check("dual_rob_valid", 32'(rob_valid), 32'h1);
        check("dual_cdb_id",    32'(cdb_id),    32'h9);
        check("dual_rob_value", 32'(rob_value), 32'hE1);

        // Reset mid-transfer with pointers parked at 2
        step(); cdb_req = 4'b0010; rob_req = 4'b0010; #1;
        check("pre_rst_cdb_grant", 32'(cdb_grant), 32'h2);
        check("pre_rst_rob_grant", 32'(rob_grant), 32'h2);
        step(); cdb_req = 4'b0110; rob_req = 4'b0110; rst = 1'b1; #1;
        check("mid_rst_cdb_grant", 32'(cdb_grant), 32'h0);
        check("mid_rst_rob_grant", 32'(rob_grant), 32'h0);
        step(); rst = 1'b0; #1;
        check("mid_rst_cdb_valid", 32'(cdb_valid), 32'h0);
        check("mid_rst_rob_valid", 32'(rob_valid), 32'h0);
        check("mid_rst_cdb_id",    32'(cdb_id),    32'h0);
        check("mid_rst_ptr_cdb",   32'(cdb_grant), 32'h2);
        check("mid_rst_ptr_rob",   32'(rob_grant), 32'h2);

        // Mixed traffic with intermittent rob_ready, checked by the model
        for (int k = 0; k < 30; k++) begin
            step();
            cdb_req   = 4'(k * 7 + 3);
            rob_req   = 4'(k * 11 + 5);
            rob_ready = ((k % 3) != 0);
            for (int i = 0; i < N; i++) begin
                set_cdb(i, RW'(k + i), DW'(k * 13 + i * 3));
                set_rob(i, RW'(k * 3 + i), DW'(k + 40 + i), DW'(k * 5 + i), DW'(k * 17 + i));
            end
        end
        step(); cdb_req = '0; rob_req = '0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
